// File: rtl/cfg_resp_mux.sv
// cfg_resp_mux: merges cs and timeout responses, enforces one outstanding config request,
// and fences the port after a timeout while discarding and counting stale cs responses.
module cfg_resp_mux #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2,
  parameter logic [RESP_WIDTH-1:0] SLAVE_ERROR = 2'b10,
  parameter logic [DATA_WIDTH-1:0] TO_READDATA = 32'hFFFF_FFFF,
  parameter int DRAIN_CYCLES = 1024,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  h_read_i,
  input  logic                  h_write_i,
  input  logic [ADDR_WIDTH-1:0] h_address_i,
  output logic                  h_waitrequest_o,
  output logic                  h_readdatavalid_o,
  output logic [DATA_WIDTH-1:0] h_readdata_o,
  output logic [RESP_WIDTH-1:0] h_resp_o,
  output logic                  h_writerespvalid_o,
  output logic                  cs_read_o,
  output logic                  cs_write_o,
  input  logic                  cs_waitrequest_i,
  input  logic                  cs_readdatavalid_i,
  input  logic [DATA_WIDTH-1:0] cs_readdata_i,
  input  logic [RESP_WIDTH-1:0] cs_resp_i,
  input  logic                  cs_writerespvalid_i,
  input  logic                  to_mux_sel_i,
  input  logic                  to_readdatavalid_i,
  input  logic                  to_writerespvalid_i,
  input  logic                  late_clr_i,
  output logic [CNT_WIDTH-1:0]  late_cnt_o,
  output logic                  late_sticky_o,
  output logic [CNT_WIDTH-1:0]  timeout_cnt_o,
  output logic [1:0]            state_o
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, DRAIN = 2'd2} state_t;
  state_t state;
  logic is_write;
  logic [DW-1:0] drain_cnt;
  logic block, accept, cs_any, cs_match, cs_wrong, to_hit, to_fire, late_inc, rd_fwd, wr_fwd;
  logic unused_addr;
  assign unused_addr = ^h_address_i[ADDR_WIDTH-2:0];
  assign block = state != IDLE;
  assign cs_read_o = h_read_i & ~block;
  assign cs_write_o = h_write_i & ~block;
  assign h_waitrequest_o = cs_waitrequest_i | block;
  assign state_o = state;
  assign accept = (cs_read_o | cs_write_o) & ~cs_waitrequest_i;
  assign cs_any = cs_readdatavalid_i | cs_writerespvalid_i;
  assign cs_match = is_write ? cs_writerespvalid_i : cs_readdatavalid_i;
  assign cs_wrong = is_write ? cs_readdatavalid_i : cs_writerespvalid_i;
  assign to_hit = to_mux_sel_i & (to_readdatavalid_i | to_writerespvalid_i);
  // A matching cs response in the same cycle beats the timeout
  assign to_fire = (state == PEND) & ~cs_match & to_hit;
  assign late_inc = ((state == PEND) & cs_wrong) | ((state == DRAIN) & cs_any);
  assign rd_fwd = cs_readdatavalid_i & ((state == IDLE) | ((state == PEND) & ~is_write));
  assign wr_fwd = cs_writerespvalid_i & ((state == IDLE) | ((state == PEND) & is_write));
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      is_write <= 1'b0;
      drain_cnt <= '0;
      h_readdatavalid_o <= 1'b0;
      h_writerespvalid_o <= 1'b0;
      h_readdata_o <= '0;
      h_resp_o <= '0;
      late_cnt_o <= '0;
      late_sticky_o <= 1'b0;
      timeout_cnt_o <= '0;
    end else begin
      h_readdatavalid_o <= rd_fwd | (to_fire & ~is_write);
      h_writerespvalid_o <= wr_fwd | (to_fire & is_write);
      if (to_fire) begin
        h_readdata_o <= is_write ? '0 : TO_READDATA;
        h_resp_o <= SLAVE_ERROR;
      end else if (rd_fwd | wr_fwd) begin
        h_readdata_o <= cs_readdata_i;
        h_resp_o <= cs_resp_i;
      end
      if (to_fire && !(&timeout_cnt_o)) timeout_cnt_o <= timeout_cnt_o + CNT_WIDTH'(1);
      if (late_clr_i) late_cnt_o <= late_inc ? CNT_WIDTH'(1) : '0;
      else if (late_inc && !(&late_cnt_o)) late_cnt_o <= late_cnt_o + CNT_WIDTH'(1);
      late_sticky_o <= (late_sticky_o & ~late_clr_i) | late_inc;
      unique case (state)
        IDLE: if (accept && !h_address_i[ADDR_WIDTH-1]) begin
          state <= PEND;
          is_write <= cs_write_o;
        end
        PEND: if (cs_match) state <= IDLE;
        else if (to_hit) begin
          state <= DRAIN;
          drain_cnt <= DRAIN_LOAD;
        end
        DRAIN: if (cs_any || drain_cnt == '0) state <= IDLE;
        else drain_cnt <= drain_cnt - DW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule
